vga_sync_gen: RTL

- Generates the VGA raster for the snake display: pixel-enable tick, horizontal and vertical counters, active-low hsync/vsync, video_on, and frame/line strobes.
- It is the driving end of the pixel interface. The graphics block consumes its pix_x, pix_y and video_on, and returns graph_rgb.
- It also owns the final RGB output register, so that colour is blanked and registered before the DAC pins.

---
 rtl/vga_sync_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// VGA raster generator for the snake display. It divides the system clock
// down to a pixel-enable tick, runs the horizontal/vertical counters, produces
// active-low hsync/vsync, video_on and line/frame strobes, and owns the final
// blanked RGB output register that feeds the DAC pins.
//
// Optional build macro: VGA_SYNC_ALIGN_EN
//   When defined, hsync/vsync get one extra p_tick-enabled register stage so
//   they line up with the registered rgb (one pixel later than the counters).
//   When undefined, hsync/vsync line up with pix_x/pix_y.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset_n     in   1   asynchronous active-low reset
//   graph_rgb   in   3   colour from the graphics block for pix_x/pix_y
//   p_tick      out  1   pixel enable, one clk wide
//   pix_x       out  10  horizontal counter
//   pix_y       out  10  vertical counter
//   video_on    out  1   high inside the visible area
//   hsync       out  1   active-low horizontal sync
//   vsync       out  1   active-low vertical sync
//   rgb         out  3   registered, blanked colour to the pins
//   line_tick   out  1   one-clk pulse after each horizontal wrap
//   frame_tick  out  1   one-clk pulse after each full-frame wrap
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] graph_rgb,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    // A 1-bit divider is kept even for CLK_DIV=1 so the vector is never empty.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    // Counters are 10 bits wide, so larger rasters cannot be represented.
    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] divider;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             x_end;
    logic             y_end;
    logic             hsync_q;
    logic             vsync_q;

    // Gated by reset_n so p_tick reads 0 during reset even when CLK_DIV=1.
    assign p_tick   = reset_n && (divider == DIV_LAST);
    assign video_on = (pix_x < H_VIS) && (pix_y < V_VIS);
    assign x_end    = (pix_x == H_LAST);
    assign y_end    = (pix_y == V_LAST);

    // Next-state counters; sync is decoded from these so the registered
    // hsync/vsync describe the same pixel as the registered counters.
    always_comb begin
        x_next = pix_x;
        y_next = pix_y;
        if (p_tick) begin
            x_next = x_end ? 10'd0 : pix_x + 10'd1;
            if (x_end) begin
                y_next = y_end ? 10'd0 : pix_y + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider    <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb        <= '0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            divider    <= p_tick ? '0 : divider + DIV_W'(1);
            pix_x      <= x_next;
            pix_y      <= y_next;
            hsync_q    <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync_q    <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            line_tick  <= p_tick && x_end;
            frame_tick <= p_tick && x_end && y_end;
            if (p_tick) begin
                rgb <= video_on ? graph_rgb : 3'b000;
            end
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_d;
    logic vsync_d;

    // Delays sync by one pixel so it matches the one-pixel rgb latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else if (p_tick) begin
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
        end
    end

    assign hsync = hsync_d;
    assign vsync = vsync_d;
`else
    assign hsync = hsync_q;
    assign vsync = vsync_q;
`endif

endmodule
